// File: rtl/lcd_seq_pkg.sv
// State encodings and per-state output decode for the LCD panel power sequencer.
// COOL is not a separate encoding: it is ST_OFF with the sequencer's cool flag set.
package lcd_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_PWR_UP = 3'd1,
    ST_VID_UP = 3'd2,
    ST_BL_UP  = 3'd3,
    ST_RUN    = 3'd4,
    ST_BL_DN  = 3'd5,
    ST_VID_DN = 3'd6,
    ST_VDD_DN = 3'd7
  } lcd_state_t;

  typedef struct packed {
    logic vdd;
    logic video;
    logic led;
    logic pwm;
  } seq_out_t;

  localparam seq_out_t OUT_OFF    = 4'b0000;
  localparam seq_out_t OUT_PWR_UP = 4'b1000;
  localparam seq_out_t OUT_VID_UP = 4'b1100;
  localparam seq_out_t OUT_BL_UP  = 4'b1110;
  localparam seq_out_t OUT_RUN    = 4'b1111;
  localparam seq_out_t OUT_BL_DN  = 4'b1110;
  localparam seq_out_t OUT_VID_DN = 4'b1100;
  localparam seq_out_t OUT_VDD_DN = 4'b1000;
  localparam seq_out_t OUT_COOL   = 4'b0000;

endpackage

// File: rtl/lcd_bl_pwm.sv
// Backlight PWM: prescaler, 8-bit period counter and period-aligned brightness latch.
// Output is a register gated by enable, so it drops on the same edge enable drops.
module lcd_bl_pwm #(
  parameter int PWM_PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] brightness,
  output logic       pwm
);

  localparam int PS_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PWM_PRESCALE - 1);

  logic [PS_W-1:0] presc;
  logic [7:0]      pwm_cnt;
  logic [7:0]      bright_q;
  logic            pwm_q;
  logic            step;

  assign step = (presc == PS_LAST);

  // While idle the counter sits at the start of a period, so the first RUN
  // cycle already carries the right compare result for count 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      pwm_cnt  <= '0;
      bright_q <= '0;
      pwm_q    <= 1'b0;
    end else if (!enable) begin
      presc    <= '0;
      pwm_cnt  <= '0;
      bright_q <= brightness;
      pwm_q    <= (brightness != 8'd0);
    end else if (step) begin
      presc   <= '0;
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_cnt == 8'hFF) begin
        bright_q <= brightness;
        pwm_q    <= (brightness != 8'd0);
      end else begin
        pwm_q <= ((pwm_cnt + 8'd1) < bright_q);
      end
    end else begin
      presc <= presc + PS_W'(1);
    end
  end

  assign pwm = enable & pwm_q;

endmodule

// File: rtl/lcd_power_seq.sv
// Panel VDD / video / backlight power sequencer with timed up/down phases and cooldown.
// Outputs register on the edge entering each state; aborts mid power-up unwind from the matching down state.
module lcd_power_seq
  import lcd_seq_pkg::*;
#(
  parameter int T_VDD        = 4000,
  parameter int T_VID        = 14400,
  parameter int T_BL         = 720,
  parameter int T_COOL       = 36000,
  parameter int PWM_PRESCALE = 4,
  parameter int CNT_W        = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power_req,
  input  logic       link_locked,
  input  logic [7:0] brightness,
  output logic       panel_vdd_en,
  output logic       video_en,
  output logic       led_en,
  output logic       led_pwm,
  output logic       ready,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] D_VDD  = CNT_W'(T_VDD - 1);
  localparam logic [CNT_W-1:0] D_VID  = CNT_W'(T_VID - 1);
  localparam logic [CNT_W-1:0] D_BL   = CNT_W'(T_BL - 1);
  localparam logic [CNT_W-1:0] D_COOL = CNT_W'(T_COOL - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic             go;
  lcd_state_t       st;
  logic             cool;
  logic [CNT_W-1:0] cnt;
  seq_out_t         outs;

  assign go = power_req & link_locked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= ST_OFF;
      cool <= 1'b0;
      cnt  <= '0;
      outs <= OUT_OFF;
    end else begin
      case (st)
        ST_OFF: begin
          if (cool) begin
            if (cnt == '0) cool <= 1'b0;
            else           cnt  <= cnt - ONE;
          end else if (go) begin
            st <= ST_PWR_UP; cnt <= D_VDD; outs <= OUT_PWR_UP;
          end
        end
        ST_PWR_UP: begin
          if (!go) begin
            st <= ST_VDD_DN; cnt <= D_VDD; outs <= OUT_VDD_DN;
          end else if (cnt == '0) begin
            st <= ST_VID_UP; cnt <= D_VID; outs <= OUT_VID_UP;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        ST_VID_UP: begin
          if (!go) begin
            st <= ST_VID_DN; cnt <= D_VID; outs <= OUT_VID_DN;
          end else if (cnt == '0) begin
            st <= ST_BL_UP; cnt <= D_BL; outs <= OUT_BL_UP;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        ST_BL_UP: begin
          if (!go) begin
            st <= ST_BL_DN; cnt <= D_BL; outs <= OUT_BL_DN;
          end else if (cnt == '0) begin
            st <= ST_RUN; outs <= OUT_RUN;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        ST_RUN: begin
          if (!go) begin
            st <= ST_BL_DN; cnt <= D_BL; outs <= OUT_BL_DN;
          end
        end
        // Down phases ignore go: once started, the panel always reaches OFF.
        ST_BL_DN: begin
          if (cnt == '0) begin
            st <= ST_VID_DN; cnt <= D_VID; outs <= OUT_VID_DN;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        ST_VID_DN: begin
          if (cnt == '0) begin
            st <= ST_VDD_DN; cnt <= D_VDD; outs <= OUT_VDD_DN;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        ST_VDD_DN: begin
          if (cnt == '0) begin
            st <= ST_OFF; cool <= 1'b1; cnt <= D_COOL; outs <= OUT_COOL;
          end else begin
            cnt <= cnt - ONE;
          end
        end
      endcase
    end
  end

  lcd_bl_pwm #(
    .PWM_PRESCALE(PWM_PRESCALE)
  ) u_bl_pwm (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (outs.pwm),
    .brightness(brightness),
    .pwm       (led_pwm)
  );

  assign panel_vdd_en = outs.vdd;
  assign video_en     = outs.video;
  assign led_en       = outs.led;
  assign ready        = outs.pwm;
  assign state        = st;

endmodule

// File: tb/tb_lcd_power_seq.sv
// Directed bench for lcd_power_seq with short delays (T_VDD=4, T_VID=3, T_BL=2, T_COOL=5, prescale 1).
module tb_lcd_power_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       power_req = 1'b0;
  logic       link_locked = 1'b1;
  logic [7:0] brightness = 8'd255;
  logic       panel_vdd_en, video_en, led_en, led_pwm, ready;
  logic [2:0] state;

  lcd_power_seq #(
    .T_VDD(4), .T_VID(3), .T_BL(2), .T_COOL(5), .PWM_PRESCALE(1), .CNT_W(24)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .power_req   (power_req),
    .link_locked (link_locked),
    .brightness  (brightness),
    .panel_vdd_en(panel_vdd_en),
    .video_en    (video_en),
    .led_en      (led_en),
    .led_pwm     (led_pwm),
    .ready       (ready),
    .state       (state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Output vector order: {vdd, video, led_en, led_pwm, ready}
  localparam logic [4:0] O_OFF = 5'b00000;
  localparam logic [4:0] O_PU  = 5'b10000;
  localparam logic [4:0] O_VU  = 5'b11000;
  localparam logic [4:0] O_BU  = 5'b11100;
  localparam logic [4:0] O_RUN = 5'b11111;

  typedef struct {
    logic       preq;
    logic       lock;
    logic [2:0] st;
    logic [4:0] o;
  } vec_t;

  vec_t vq[$];

  function automatic logic [4:0] outs_now();
    return {panel_vdd_en, video_en, led_en, led_pwm, ready};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic p, input logic l, input logic [2:0] s,
                     input logic [4:0] o, input int n);
    for (int i = 0; i < n; i++) vq.push_back('{preq: p, lock: l, st: s, o: o});
  endtask

  initial begin
    int hi [4];
    logic [2:0] ls [16];

    // Reset state
    repeat (2) tick();
    chk("reset state", int'(state), 0);
    chk("reset outs", int'(outs_now()), int'(O_OFF));
    rst_n = 1'b1;
    tick();
    chk("idle state", int'(state), 0);

    // Nominal power-up, run, power-down to OFF (brightness 255)
    add(1, 1, 3'd1, O_PU, 4);
    add(1, 1, 3'd2, O_VU, 3);
    add(1, 1, 3'd3, O_BU, 2);
    add(1, 1, 3'd4, O_RUN, 2);
    add(0, 1, 3'd5, O_BU, 2);
    add(0, 1, 3'd6, O_VU, 3);
    add(0, 1, 3'd7, O_PU, 4);
    add(0, 1, 3'd0, O_OFF, 5);
    add(0, 1, 3'd0, O_OFF, 1);
    // Abort in the second cycle of VID_UP; led_en must never rise
    add(1, 1, 3'd1, O_PU, 4);
    add(1, 1, 3'd2, O_VU, 2);
    add(0, 1, 3'd6, O_VU, 3);
    add(0, 1, 3'd7, O_PU, 4);
    add(0, 1, 3'd0, O_OFF, 5);

    for (int i = 0; i < vq.size(); i++) begin
      power_req   = vq[i].preq;
      link_locked = vq[i].lock;
      tick();
      chk($sformatf("row%0d state", i), int'(state), int'(vq[i].st));
      chk($sformatf("row%0d outs", i), int'(outs_now()), int'(vq[i].o));
    end

    // PWM duty: 64, then 128 set mid-period, then 0 set mid-period
    power_req = 1'b0;
    tick();
    chk("cool done", int'(state), 0);
    brightness = 8'd64;
    power_req  = 1'b1;
    repeat (9) tick();
    for (int p = 0; p < 4; p++) hi[p] = 0;
    for (int k = 0; k < 1024; k++) begin
      tick();
      if (k == 0) chk("pwm run entry", int'(state), 4);
      if (led_pwm) hi[k / 256]++;
      if (k == 356) brightness = 8'd128;
      if (k == 600) brightness = 8'd0;
    end
    chk("pwm period0 64", hi[0], 64);
    chk("pwm period1 still 64", hi[1], 64);
    chk("pwm period2 128", hi[2], 128);
    chk("pwm period3 zero", hi[3], 0);

    // One-cycle link_locked drop in RUN; power_req held high throughout
    ls = '{3'd5, 3'd5, 3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7,
           3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    link_locked = 1'b0;
    for (int r = 0; r < 16; r++) begin
      tick();
      link_locked = 1'b1;
      chk($sformatf("lockdrop r%0d state", r + 1), int'(state), int'(ls[r]));
      if (r == 0) chk("lockdrop pwm off", int'(led_pwm), 0);
      if (r == 9) chk("lockdrop vdd off", int'(panel_vdd_en), 0);
    end

    // Asynchronous reset in the middle of BL_UP
    repeat (7) tick();
    chk("pre-reset state", int'(state), 3);
    chk("pre-reset outs", int'(outs_now()), int'(O_BU));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset state", int'(state), 0);
    chk("async reset outs", int'(outs_now()), int'(O_OFF));
    repeat (2) begin
      tick();
      chk("held reset outs", int'(outs_now()), int'(O_OFF));
    end
    rst_n = 1'b1;
    tick();
    chk("post-reset power-up", int'(state), 1);
    chk("post-reset vdd", int'(panel_vdd_en), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
